// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin front end for two word requesters feeding a
// serial 3-bit sequence detector; one word at a time, MSB first.
module seq_det_scheduler #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  input  logic [2:0]    cfg_pattern,
  input  logic          cfg_overlap,
  output logic          busy,
  output logic          det_out,
  output logic          done,
  output logic          done_id,
  output logic [CW-1:0] match_cnt
);

  localparam int BW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [W-1:0]  data_r;
  logic          id_r;
  logic [2:0]    pat_r;
  logic          ovl_r;
  logic [1:0]    hist_r;
  logic [1:0]    fresh_r;
  logic [CW-1:0] cnt_r;
  logic [BW-1:0] bit_cnt_r;
  logic          last_r;
  logic [CW-1:0] match_cnt_r;
  logic          done_id_r;

  logic          grant_s;
  logic          xfer_s;
  logic          bit_s;
  logic          match_s;
  logic          last_bit_s;
  logic [CW-1:0] cnt_nxt_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + CW'(1);
  endfunction

  // Requester selection: alternate under contention, otherwise take whoever is valid.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_s = ~last_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Rst gates the handshake so no word is accepted while reset is held.
  assign xfer_s     = Rst && (state_r == IDLE) && (req0_valid || req1_valid);
  assign bit_s      = data_r[W-1];
  assign match_s    = (state_r == SHIFT) && fresh_r[1] && ({hist_r, bit_s} == pat_r);
  assign last_bit_s = (bit_cnt_r == BW'(W - 1));
  assign cnt_nxt_s  = match_s ? sat_inc(cnt_r) : cnt_r;

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = xfer_s ? SHIFT : IDLE;
      SHIFT:   state_nxt_s = last_bit_s ? REPORT : SHIFT;
      REPORT:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Word capture, serial detection history and result latching.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      data_r      <= '0;
      id_r        <= 1'b0;
      pat_r       <= 3'd0;
      ovl_r       <= 1'b0;
      hist_r      <= 2'd0;
      fresh_r     <= 2'd0;
      cnt_r       <= '0;
      bit_cnt_r   <= '0;
      last_r      <= 1'b1;
      match_cnt_r <= '0;
      done_id_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            data_r    <= grant_s ? req1_data : req0_data;
            id_r      <= grant_s;
            pat_r     <= cfg_pattern;
            ovl_r     <= cfg_overlap;
            hist_r    <= 2'd0;
            fresh_r   <= 2'd0;
            cnt_r     <= '0;
            bit_cnt_r <= '0;
            last_r    <= grant_s;
          end
        end
        SHIFT: begin
          data_r    <= {data_r[W-2:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + BW'(1);
          hist_r    <= {hist_r[0], bit_s};
          cnt_r     <= cnt_nxt_s;
          // Non-overlapping mode restarts the fresh-bit window after a hit.
          if (match_s && !ovl_r) begin
            fresh_r <= 2'd0;
          end else if (fresh_r != 2'd3) begin
            fresh_r <= fresh_r + 2'd1;
          end
          if (last_bit_s) begin
            match_cnt_r <= cnt_nxt_s;
            done_id_r   <= id_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    det_out    = match_s;
    match_cnt  = match_cnt_r;
    done_id    = done_id_r;
    case (state_r)
      IDLE: begin
        req0_ready = xfer_s & ~grant_s;
        req1_ready = xfer_s & grant_s;
      end
      SHIFT: begin
        busy = 1'b1;
      end
      REPORT: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Scoreboard bench for seq_det_scheduler: a CW=4 and a CW=2 instance share
// all stimulus; expected words are queued at acceptance and checked at done.
`timescale 1ns/1ps
module tb_seq_det_scheduler;
  localparam int W = 8;

  typedef struct {
    bit           id;
    logic [W-1:0] det;
    int           raw;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic [2:0]   cfg_pattern = 3'd0;
  logic         cfg_overlap = 1'b0;

  logic       r0_ready, r1_ready, busy, det_out, done, done_id;
  logic [3:0] match_cnt;
  logic       s_r0_ready, s_r1_ready, s_busy, s_det_out, s_done, s_done_id;
  logic [1:0] s_match_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   mon_k = 0;
  int   words_done [2];
  int   last_acc [2];
  exp_t sb [$];
  bit   acc_order [$];

  seq_det_scheduler #(.W(W), .CW(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_ready),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .busy(busy), .det_out(det_out), .done(done), .done_id(done_id),
    .match_cnt(match_cnt)
  );

  seq_det_scheduler #(.W(W), .CW(2)) dut_s (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_r0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_r1_ready),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .busy(s_busy), .det_out(s_det_out), .done(s_done), .done_id(s_done_id),
    .match_cnt(s_match_cnt)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference detector: index i is the i-th serial bit, MSB first.
  function automatic void model(input logic [W-1:0] d, input logic [2:0] p, input bit ov,
                                output logic [W-1:0] det, output int raw);
    int       fresh;
    logic [1:0] h;
    logic     b;
    bit       hit;
    fresh = 0; h = 2'b00; raw = 0; det = '0;
    for (int i = 0; i < W; i++) begin
      b   = d[W-1-i];
      hit = (fresh >= 2) && ({h, b} == p);
      if (hit) begin
        det[i] = 1'b1;
        raw++;
      end
      fresh = (hit && !ov) ? 0 : fresh + 1;
      h = {h[0], b};
    end
  endfunction

  task automatic offer(input bit id, input logic [W-1:0] d);
    int           n;
    bit           acc;
    logic [W-1:0] det;
    int           raw;
    exp_t         e;
    if (id) begin req1_data = d; req1_valid = 1'b1; end
    else    begin req0_data = d; req0_valid = 1'b1; end
    n = 0; acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge Clk);
      if (Rst && (id ? r1_ready : r0_ready)) acc = 1'b1;
      n++;
    end
    check_eq(id ? "accept_wait1" : "accept_wait0", {31'd0, acc}, 32'd1);
    if (acc) begin
      model(d, cfg_pattern, cfg_overlap, det, raw);
      e.id = id; e.det = det; e.raw = raw;
      sb.push_back(e);
      acc_order.push_back(id);
      last_acc[id] = cyc;
    end
    @(posedge Clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge Clk);
      if (done) seen = 1'b1;
      n++;
    end
    check_eq("done_wait", {31'd0, seen}, 32'd1);
  endtask

  // Monitor: checks every cycle against the scoreboard front entry.
  initial begin
    exp_t cur;
    int   e4, e2;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        check_eq("rst_outs", {r0_ready, r1_ready, busy, det_out, done, done_id, match_cnt}, 32'd0);
        check_eq("rst_outs_s", {s_r0_ready, s_r1_ready, s_busy, s_det_out, s_done, s_done_id, s_match_cnt}, 32'd0);
        mon_k = 0;
        sb.delete();
      end else if (mon_k == 0) begin
        check_eq("idle_outs", {busy, det_out, done}, 32'd0);
        if ((r0_ready && req0_valid) || (r1_ready && req1_valid)) begin
          check_eq("grant_onehot", {31'd0, r0_ready & r1_ready}, 32'd0);
          mon_k = 1;
        end
      end else begin
        check_eq("sb_has_entry", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          cur = sb[0];
          if (mon_k <= W) begin
            check_eq("det_bit", {31'd0, det_out}, {31'd0, cur.det[mon_k-1]});
            check_eq("det_bit_s", {31'd0, s_det_out}, {31'd0, cur.det[mon_k-1]});
            check_eq("shift_outs", {busy, done, r0_ready, r1_ready}, 32'b1000);
            mon_k++;
          end else begin
            e4 = (cur.raw > 15) ? 15 : cur.raw;
            e2 = (cur.raw > 3) ? 3 : cur.raw;
            check_eq("done_pulse", {30'd0, done, s_done}, 32'b11);
            check_eq("done_id", {31'd0, done_id}, {31'd0, cur.id});
            check_eq("match_cnt", {28'd0, match_cnt}, e4);
            check_eq("match_cnt_s", {30'd0, s_match_cnt}, e2);
            words_done[cur.id]++;
            void'(sb.pop_front());
            mon_k = 0;
          end
        end else begin
          mon_k = 0;
        end
      end
    end
  end

  initial begin
    words_done[0] = 0; words_done[1] = 0;
    last_acc[0] = 0;   last_acc[1] = 0;

    // Reset with both requesters offering: ready must stay low.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(posedge Clk);
    #2;
    check_eq("rst_ready", {30'd0, r0_ready, r1_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    Rst = 1'b1;
    @(posedge Clk); #1;

    // Contention straight out of reset.
    cfg_pattern = 3'b101; cfg_overlap = 1'b1;
    fork
      offer(1'b0, 8'hAA);
      offer(1'b1, 8'h55);
    join
    wait_done();
    check_eq("cont_order_len", acc_order.size(), 32'd2);
    if (acc_order.size() >= 2) begin
      check_eq("cont_first", {31'd0, acc_order[0]}, 32'd0);
      check_eq("cont_second", {31'd0, acc_order[1]}, 32'd1);
    end
    check_eq("cont_spacing", last_acc[1] - last_acc[0], W + 2);
    check_eq("cont_words", {words_done[0][15:0], words_done[1][15:0]}, 32'h0001_0001);

    // Overlapping detection of 101 in 0xAA.
    @(posedge Clk); #1;
    offer(1'b0, 8'hAA);
    wait_done();
    check_eq("ovl_cnt", {28'd0, match_cnt}, 32'd3);
    check_eq("ovl_id", {31'd0, done_id}, 32'd0);

    // Non-overlapping detection of the same word.
    @(posedge Clk); #1;
    cfg_overlap = 1'b0;
    offer(1'b0, 8'hAA);
    wait_done();
    check_eq("novl_cnt", {28'd0, match_cnt}, 32'd2);

    // Config changed mid-word must not disturb the word in flight.
    @(posedge Clk); #1;
    cfg_overlap = 1'b1;
    offer(1'b0, 8'hAA);
    cfg_pattern = 3'b010; cfg_overlap = 1'b0;
    wait_done();
    check_eq("cfg_hold_cnt", {28'd0, match_cnt}, 32'd3);

    // Saturation: six raw hits, CW=2 instance clips to 3.
    @(posedge Clk); #1;
    cfg_pattern = 3'b111; cfg_overlap = 1'b1;
    offer(1'b0, 8'hFF);
    wait_done();
    check_eq("sat_cnt4", {28'd0, match_cnt}, 32'd6);
    check_eq("sat_cnt2", {30'd0, s_match_cnt}, 32'd3);

    // Back-to-back words from requester 1 only.
    @(posedge Clk); #1;
    cfg_pattern = 3'b110;
    offer(1'b1, 8'($urandom));
    for (int i = 0; i < 3; i++) begin
      int prev;
      prev = last_acc[1];
      offer(1'b1, 8'($urandom));
      check_eq("b2b_spacing", last_acc[1] - prev, W + 2);
    end
    wait_done();

    // Reset at bit index 4 of a word; a pending req1 word must complete after.
    @(posedge Clk); #1;
    cfg_pattern = 3'b101; cfg_overlap = 1'b1;
    offer(1'b0, 8'hAA);
    repeat (4) @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    check_eq("async_rst", {r0_ready, r1_ready, busy, det_out, done, done_id, match_cnt}, 32'd0);
    fork
      offer(1'b1, 8'h5D);
      begin
        repeat (3) @(posedge Clk);
        #2;
        Rst = 1'b1;
      end
    join
    wait_done();
    check_eq("post_rst_id", {31'd0, done_id}, 32'd1);
    check_eq("post_rst_cnt", {28'd0, match_cnt}, 32'd2);

    // Random words, patterns and modes.
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      cfg_pattern = 3'($urandom_range(0, 7));
      cfg_overlap = 1'($urandom_range(0, 1));
      offer(1'($urandom_range(0, 1)), 8'($urandom));
      wait_done();
    end

    repeat (3) @(posedge Clk);
    check_eq("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_det_scheduler.md
SEQ_DET_SCHEDULER -- requirements
Module: seq_det_scheduler

Interface
REQ-001 The block SHALL have parameter W, default 8: data word width in bits.
REQ-002 The block SHALL have parameter CW, default 4: match counter width.
REQ-003 The block SHALL have port Clk  in  1: clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Rst  in  1: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports req0_valid  in  1 and req0_data  in  W: requester 0 word offer.
REQ-006 The block SHALL have port req0_ready  out  1: requester 0 word accepted this cycle when high with req0_valid.
REQ-007 The block SHALL have ports req1_valid  in  1, req1_data  in  W and req1_ready  out  1: requester 1, same meaning as requester 0.
REQ-008 The block SHALL have port cfg_pattern  in  3: 3-bit target sequence, oldest bit in bit 2.
REQ-009 The block SHALL have port cfg_overlap  in  1: 1 = overlapping detection, 0 = non-overlapping.
REQ-010 The block SHALL have port busy  out  1: a word is being processed.
REQ-011 The block SHALL have port det_out  out  1: Mealy match strobe for the current serial bit.
REQ-012 The block SHALL have port done  out  1: single-cycle word-complete pulse.
REQ-013 The block SHALL have port done_id  out  1: requester index of the completed word.
REQ-014 The block SHALL have port match_cnt  out  CW: match count of the completed word.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and REPORT.
REQ-016 In IDLE with any valid, the block SHALL grant exactly one requester.
  - Both valid: grant the requester not granted last.
  - One valid: grant that requester (work-conserving).
REQ-017 The granted ready SHALL be driven combinationally high in IDLE only; the transfer completes on ready&valid.
REQ-018 On transfer, the block SHALL latch data, id, cfg_pattern and cfg_overlap, clear history and the count, and enter SHIFT.
REQ-019 In SHIFT, the block SHALL consume one bit per cycle, MSB first, for exactly W cycles, then enter REPORT.
REQ-020 The block SHALL flag a match on a bit when at least 3 fresh bits are held and {prev2, prev1, bit} equals the latched pattern; det_out SHALL be high in that same cycle.
REQ-021 With overlap=1, history SHALL continue after a match; with overlap=0, the fresh-bit count SHALL reset to 0 after a match.
REQ-022 History SHALL NOT carry across words.
REQ-023 The match count SHALL saturate at 2^CW-1.
REQ-024 In REPORT, the block SHALL drive done=1 for one cycle and then return to IDLE.
  - done_id and match_cnt SHALL be valid when done=1 and SHALL be held until the next transfer.
REQ-025 Timing SHALL be: transfer at cycle T, bits at T+1..T+W, done at T+W+1, next transfer no earlier than T+W+2.
REQ-026 busy SHALL be high in SHIFT and REPORT; both ready outputs SHALL be low there.
REQ-027 Changes to cfg_pattern or cfg_overlap during SHIFT SHALL NOT affect the word in progress.
REQ-028 det_out SHALL be 0 outside SHIFT.

Reset
REQ-029 Rst low SHALL immediately force IDLE and drive req0_ready, req1_ready, busy, det_out, done, done_id and match_cnt to 0.
REQ-030 Rst low SHALL clear history and set the last-grant pointer so requester 0 wins the first contention.
REQ-031 Reset during SHIFT or REPORT SHALL abort the word with no done pulse.

Verification
REQ-032 Overlap case: req0 0b10101010, pattern 101, overlap=1 -> det_out at bit indices 2, 4, 6; done at T+9; match_cnt=3; done_id=0.
REQ-033 Non-overlap case: same word with overlap=0 -> matches at indices 2 and 6; match_cnt=2.
REQ-034 Contention: both valid from reset -> req0 granted first, req1 next; done_id sequence 0, 1; no lost words.
REQ-035 Back-to-back single requester: only req1 valid -> req1 granted every IDLE visit; transfer spacing W+2 cycles.
REQ-036 Mid-word reset: Rst low at bit 4 of a word -> all outputs 0, no done; after release, a pending req1 is accepted and completes normally.
REQ-037 Saturation: CW=2, data 0xFF, pattern 111, overlap=1 -> 6 raw matches; match_cnt=3.
